// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: command FIFO, credit-limited issue to a registered ALU, in-order result FIFO
module alu_op_sequencer #(
    parameter int         CMD_DEPTH = 4,
    parameter int         RES_DEPTH = 4,
    parameter int         ALU_LAT   = 1,
    parameter logic [3:0] IDLE_OP   = 4'hF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [3:0] cmd_a,
    input  logic [3:0] cmd_b,
    input  logic [3:0] cmd_op,
    output logic       res_valid,
    input  logic       res_ready,
    output logic [7:0] res_data,
    output logic       res_carry,
    output logic       res_ovf,
    output logic       res_err,
    output logic [3:0] alu_a,
    output logic [3:0] alu_b,
    output logic [3:0] alu_op,
    input  logic [7:0] alu_result,
    input  logic       alu_carry,
    input  logic       alu_ovf,
    output logic       busy
);
    localparam int CW = $clog2(CMD_DEPTH);
    localparam int RW = $clog2(RES_DEPTH);
    localparam int PS = ALU_LAT + 1;
    localparam logic [RW+1:0] RES_LIM = (RW+2)'(RES_DEPTH);

    logic [11:0]   cmd_mem [CMD_DEPTH];
    logic [CW:0]   cmd_wp, cmd_rp;
    logic [10:0]   res_mem [RES_DEPTH];
    logic [RW:0]   res_wp, res_rp;
    logic [PS-1:0] tag_v, tag_e;
    logic [RW+1:0] inflight, res_count;
    logic [11:0]   head;
    logic          cmd_empty, cmd_full, cmd_push, issue, res_pop;

    assign cmd_empty = cmd_wp == cmd_rp;
    assign cmd_full  = (cmd_wp[CW] != cmd_rp[CW]) && (cmd_wp[CW-1:0] == cmd_rp[CW-1:0]);
    assign cmd_ready = !cmd_full;
    assign cmd_push  = cmd_valid && !cmd_full;
    assign head      = cmd_mem[cmd_rp[CW-1:0]];
    assign res_count = {1'b0, res_wp - res_rp};
    assign issue     = !cmd_empty && (inflight + res_count < RES_LIM);
    assign res_valid = res_wp != res_rp;
    assign res_pop   = res_valid && res_ready;
    assign {res_data, res_carry, res_ovf, res_err} = res_mem[res_rp[RW-1:0]];
    assign busy      = !cmd_empty || (inflight != '0) || res_valid;

    // Credits held by commands travelling through the ALU
    always_comb begin
        inflight = '0;
        for (int i = 0; i < PS; i++) inflight = inflight + {{(RW+1){1'b0}}, tag_v[i]};
    end

    // Command FIFO storage and pointers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmd_wp <= '0;
            cmd_rp <= '0;
            for (int i = 0; i < CMD_DEPTH; i++) cmd_mem[i] <= '0;
        end else begin
            if (cmd_push) begin
                cmd_mem[cmd_wp[CW-1:0]] <= {cmd_a, cmd_b, cmd_op};
                cmd_wp <= cmd_wp + 1'b1;
            end
            if (issue) cmd_rp <= cmd_rp + 1'b1;
        end
    end

    // ALU drive lines and tag pipe that shadows the ALU latency
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_a  <= '0;
            alu_b  <= '0;
            alu_op <= IDLE_OP;
            tag_v  <= '0;
            tag_e  <= '0;
        end else begin
            alu_a  <= issue ? head[11:8] : '0;
            alu_b  <= issue ? head[7:4] : '0;
            alu_op <= issue ? head[3:0] : IDLE_OP;
            tag_v  <= {tag_v[PS-2:0], issue};
            tag_e  <= {tag_e[PS-2:0], issue && (head[3:0] > 4'd8)};
        end
    end

    // Result FIFO: capture ALU outputs when a tagged command emerges
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_wp <= '0;
            res_rp <= '0;
            for (int i = 0; i < RES_DEPTH; i++) res_mem[i] <= '0;
        end else begin
            if (tag_v[PS-1]) begin
                res_mem[res_wp[RW-1:0]] <= {alu_result, alu_carry, alu_ovf, tag_e[PS-1]};
                res_wp <= res_wp + 1'b1;
            end
            if (res_pop) res_rp <= res_rp + 1'b1;
        end
    end
endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb_alu_op_sequencer: table vectors, corner sequences and randomized scoreboard for alu_op_sequencer
module tb_alu_op_sequencer;
    logic       clk = 1'b0, rst_n = 1'b0;
    logic       cmd_valid = 1'b0, res_ready = 1'b0;
    logic [3:0] cmd_a = '0, cmd_b = '0, cmd_op = '0;
    logic       cmd_ready, res_valid, res_carry, res_ovf, res_err, busy;
    logic [7:0] res_data;
    logic [3:0] alu_a, alu_b, alu_op;
    logic [7:0] alu_result = '0;
    logic       alu_carry = 1'b0, alu_ovf = 1'b0;

    typedef struct packed {
        logic [3:0] a, b, op;
        logic [7:0] d;
        logic       c, o, e;
    } vec_t;

    vec_t        tbl [11];
    logic [10:0] exp_q [$];
    logic [7:0]  got_q [$];
    int          pop_cyc [$];
    int          checks = 0, failures = 0, cyc = 0, nacc = 0, npop = 0;

    always #5 clk = ~clk;

    alu_op_sequencer dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_op(cmd_op),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_data(res_data), .res_carry(res_carry), .res_ovf(res_ovf), .res_err(res_err),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
        .alu_result(alu_result), .alu_carry(alu_carry), .alu_ovf(alu_ovf),
        .busy(busy)
    );

    // 4-bit ALU: returns {result, carry, ovf}
    function automatic logic [9:0] alu_fn(input logic [3:0] a, input logic [3:0] b, input logic [3:0] op);
        logic [4:0] s;
        logic [9:0] r;
        r = '0;
        s = '0;
        case (op)
            4'd0: begin s = {1'b0, a} + {1'b0, b}; r = {4'h0, s[3:0], s[4], (a[3] == b[3]) && (s[3] != a[3])}; end
            4'd1: begin s = {1'b0, a} - {1'b0, b}; r = {4'h0, s[3:0], a < b, (a[3] != b[3]) && (s[3] != a[3])}; end
            4'd2: r = {8'(a) * 8'(b), 2'b00};
            4'd3: r = (b == 4'd0) ? {4'hF, a, 2'b00} : {a / b, a % b, 2'b00};
            4'd4: r = {4'h0, a & b, 2'b00};
            4'd5: r = {4'h0, a | b, 2'b00};
            4'd6: r = {4'h0, a ^ b, 2'b00};
            4'd7: r = {4'h0, ~a, 2'b00};
            4'd8: r = {{a, b} ^ 8'hAB, 2'b00};
            default: r = '0;
        endcase
        return r;
    endfunction

    // Free-running ALU with one register stage
    always @(posedge clk) {alu_result, alu_carry, alu_ovf} <= alu_fn(alu_a, alu_b, alu_op);

    task automatic check(input string n, input logic [31:0] g, input logic [31:0] e);
        checks++;
        if (g !== e) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", n, g, e);
        end
    endtask

    // One clock: score handshakes seen before the edge, then advance to edge+1
    task automatic step();
        if (res_valid && res_ready) begin
            npop++;
            got_q.push_back(res_data);
            pop_cyc.push_back(cyc);
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL sb_extra got=%0h exp=none", res_data);
            end else check("sb_res", {res_data, res_carry, res_ovf, res_err}, exp_q.pop_front());
        end
        if (cmd_valid && cmd_ready) begin
            nacc++;
            exp_q.push_back({alu_fn(cmd_a, cmd_b, cmd_op), cmd_op > 4'd8});
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic drain();
        cmd_valid = 1'b0;
        res_ready = 1'b1;
        for (int k = 0; k < 40 && (busy || res_valid); k++) step();
        check("drain_empty", exp_q.size(), 0);
        check("drain_busy", busy, 0);
    endtask

    initial begin
        int lat, a0, p0;
        tbl[0]  = '{4'h7, 4'h9, 4'h0, 8'h00, 1'b1, 1'b0, 1'b0};
        tbl[1]  = '{4'h3, 4'h5, 4'h1, 8'h0E, 1'b1, 1'b0, 1'b0};
        tbl[2]  = '{4'hF, 4'hF, 4'h2, 8'hE1, 1'b0, 1'b0, 1'b0};
        tbl[3]  = '{4'hD, 4'h4, 4'h3, 8'h31, 1'b0, 1'b0, 1'b0};
        tbl[4]  = '{4'h1, 4'h2, 4'h8, 8'hB9, 1'b0, 1'b0, 1'b0};
        tbl[5]  = '{4'h5, 4'h0, 4'h7, 8'h0A, 1'b0, 1'b0, 1'b0};
        tbl[6]  = '{4'h3, 4'h4, 4'hC, 8'h00, 1'b0, 1'b0, 1'b1};
        tbl[7]  = '{4'hC, 4'hA, 4'h4, 8'h08, 1'b0, 1'b0, 1'b0};
        tbl[8]  = '{4'hC, 4'hA, 4'h5, 8'h0E, 1'b0, 1'b0, 1'b0};
        tbl[9]  = '{4'hC, 4'hA, 4'h6, 8'h06, 1'b0, 1'b0, 1'b0};
        tbl[10] = '{4'h7, 4'h1, 4'h0, 8'h08, 1'b0, 1'b1, 1'b0};

        repeat (2) @(posedge clk);
        #1;
        check("rst_flags", {cmd_ready, res_valid, busy}, 3'b100);
        check("rst_alu", {alu_a, alu_b, alu_op}, 12'h00F);
        check("rst_res", {res_data, res_carry, res_ovf, res_err}, 11'h0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        res_ready = 1'b1;
        for (int i = 0; i < 11; i++) begin
            cmd_a = tbl[i].a;
            cmd_b = tbl[i].b;
            cmd_op = tbl[i].op;
            cmd_valid = 1'b1;
            check("tbl_ready", cmd_ready, 1);
            @(posedge clk);
            #1;
            cmd_valid = 1'b0;
            @(posedge clk);
            #1;
            check("tbl_issue", {alu_a, alu_b, alu_op}, {tbl[i].a, tbl[i].b, tbl[i].op});
            lat = 1;
            while (!res_valid && lat < 10) begin
                @(posedge clk);
                #1;
                lat++;
            end
            check("tbl_lat", lat, 3);
            check("tbl_res", {res_data, res_carry, res_ovf, res_err}, {tbl[i].d, tbl[i].c, tbl[i].o, tbl[i].e});
            @(posedge clk);
            #1;
            check("tbl_idle", {res_valid, busy, alu_op}, {2'b00, 4'hF});
        end

        got_q.delete();
        pop_cyc.delete();
        for (int i = 2; i < 6; i++) begin
            cmd_a = tbl[i].a;
            cmd_b = tbl[i].b;
            cmd_op = tbl[i].op;
            cmd_valid = 1'b1;
            step();
        end
        drain();
        check("b2b_count", got_q.size(), 4);
        if (got_q.size() == 4) begin
            check("b2b_data", {got_q[0], got_q[1], got_q[2], got_q[3]}, 32'hE131B90A);
            check("b2b_consec", pop_cyc[3] - pop_cyc[0], 3);
        end

        res_ready = 1'b0;
        a0 = nacc;
        for (int i = 0; i < 20; i++) begin
            cmd_valid = 1'b1;
            {cmd_a, cmd_b, cmd_op} = 12'($urandom);
            step();
        end
        check("bp_accepted", nacc - a0, 8);
        check("bp_ready_low", cmd_ready, 0);
        p0 = npop;
        drain();
        check("bp_results", npop - p0, 8);

        a0 = nacc;
        for (int i = 0; i < 20; i++) begin
            cmd_valid = 1'b1;
            {cmd_a, cmd_b, cmd_op} = 12'($urandom);
            step();
        end
        check("tput_accepted", nacc - a0, 20);
        drain();

        for (int i = 0; i < 400; i++) begin
            cmd_valid = 1'($urandom);
            res_ready = ($urandom_range(0, 3) != 0);
            {cmd_a, cmd_b, cmd_op} = 12'($urandom);
            step();
        end
        drain();

        res_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            cmd_valid = 1'b1;
            {cmd_a, cmd_b, cmd_op} = 12'($urandom);
            step();
        end
        rst_n = 1'b0;
        #1;
        check("mrst_flags", {cmd_ready, res_valid, busy}, 3'b100);
        check("mrst_alu_op", alu_op, 4'hF);
        exp_q.delete();
        got_q.delete();
        cmd_valid = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        res_ready = 1'b1;
        cmd_a = 4'd2;
        cmd_b = 4'd2;
        cmd_op = 4'd0;
        cmd_valid = 1'b1;
        step();
        cmd_valid = 1'b0;
        for (int i = 0; i < 10; i++) step();
        check("mrst_count", got_q.size(), 1);
        if (got_q.size() == 1) check("mrst_data", got_q[0], 8'h04);
        check("mrst_busy", busy, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
